wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
Multi-lane writeback/commit stage for the superscalar MIPS pipeline; next generation of the single-issue WB stage.
- Accepts LANES instructions per cycle from MEM and writes the register file.
- Resolves in-order exception/ERET precedence across lanes and raises flush.
- Counts retired instructions.
- Serialises committed writes onto the single-entry debug trace port through a trace FIFO.

Parameters:
LANES, 2, instructions committed per cycle; lane 0 is oldest.
DATA_W, 32, register data width.
TRACE_DEPTH, 8, trace FIFO entries; power of two, >= LANES.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_to_ws_valid  in  1  MEM group valid
ws_allowin  out  1  stage can accept a group
lane_valid  in  LANES  per-lane valid within the group
lane_gr_we  in  LANES  lane writes the GPR
lane_dest  in  5*LANES  destination register
lane_result  in  DATA_W*LANES  write data
lane_pc  in  32*LANES  lane PC
lane_ex  in  LANES  lane carries an exception
lane_exccode  in  5*LANES  exception code
lane_eret  in  LANES  lane is ERET
rf_we  out  LANES  RF write enables
rf_waddr  out  5*LANES  RF write addresses
rf_wdata  out  DATA_W*LANES  RF write data
ex_commit  out  1  exception taken this cycle
ex_code  out  5  ExcCode of the taken exception
ex_pc  out  32  PC of the excepting lane
eret_commit  out  1  ERET taken this cycle
flush  out  1  pipeline flush pulse
retired_cnt  out  32  retired instruction count
debug_wb_pc  out  32  trace PC
debug_wb_rf_wen  out  4  trace write enable
debug_wb_rf_wnum  out  5  trace register number
debug_wb_rf_wdata  out  32  trace data

Behaviour:
Input register:
- Captures all lane inputs when ms_to_ws_valid && ws_allowin; ws_valid <= ms_to_ws_valid.
- ws_allowin = !ws_valid || ws_ready_go.
- Effective lane valid v[i] = ws_valid && r_lane_valid[i].
- fire = ws_valid && ws_ready_go; commit and count side effects occur only on fire, exactly once per group.

Kill mask:
- Lane i is killed if any lane j<i has v[j] && (ex[j] || eret[j]).
- Live[i] = v[i] && !killed[i].

Exception and ERET:
- The oldest live lane with ex or eret selects the event.
- ex_commit = fire && that lane's ex; ex has priority over eret within one lane.
- eret_commit = fire && that lane's eret && !ex.
- ex_code and ex_pc come from the selected lane; both are 0 when no event.
- flush = ex_commit | eret_commit; single-cycle, combinational from registered state.
- On flush, ws_valid <= 0 next cycle; a simultaneous incoming group is discarded.

RF writes:
- rf_we[i] = fire && live[i] && gr_we[i] && !ex[i] && dest[i]!=0.
- Same destination in two lanes: the younger lane wins; the older lane's rf_we is suppressed.
- rf_waddr and rf_wdata pass through from the registered lanes.

Retire counter:
- Resets to 0.
- On fire, adds the count of live lanes without ex; ERET counts as retired.
- Wraps modulo 2^32.

Trace FIFO:
- On fire, pushes one entry {pc, dest, data} per rf_we lane, in lane order, including older lanes suppressed only by the same-dest rule.
- Pops one entry per cycle when non-empty.
- ws_ready_go = (free entries >= LANES); push and pop in the same cycle are allowed.
- Empty: debug_wb_rf_wen=0 and pc/wnum/wdata=0; otherwise debug_wb_rf_wen=4'hf with head-entry fields.
- Pointers wrap at TRACE_DEPTH.

Reset:
- Clears ws_valid, the FIFO, and retired_cnt.
- Clears the input bus register to 0.
- All outputs are 0 after reset; ws_allowin=1.
- Reset mid-group drops the group with no RF write.

Optional Feature:
WB_TRACE_FIFO_EN:
- Defined: trace FIFO as above.
- Undefined: no FIFO; ws_ready_go=1; debug outputs show lane 0's commit directly (wen=4'hf when rf_we[0], else 0).

Test Plan:
- Reset -> ws_allowin=1, retired_cnt=0, all rf_we=0, debug wen=0.
- Group lane0 {pc=0xbfc00000, dest=5, data=0x11}, lane1 {pc=0xbfc00004, dest=6, data=0x22} -> rf_we=2'b11; retired_cnt=2; trace shows r5=0x11 then r6=0x22 on consecutive cycles.
- lane0 ex exccode=0x0C (Ov), lane1 write r7 -> ex_commit=1, ex_code=0x0C, ex_pc=lane0 pc, flush pulse, rf_we=0; incoming group the next cycle is discarded.
- Both lanes write r8 (0x1, 0x2) -> only rf_we[1]=1, r8=0x2; the trace carries both entries.
- Back-to-back full groups with TRACE_DEPTH=4 -> ws_allowin drops when free < 2; no trace entry is lost or duplicated.
- lane0 eret, lane1 valid -> eret_commit=1, flush=1, lane1 killed; retired_cnt increments by 1.

Source files
------------

// File: rtl/wb_commit_unit_if.sv
// MEM -> WB group handshake and lane bundle.
// master = MEM side, slave = writeback stage.
interface wb_commit_unit_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32
);
  logic                    ms_to_ws_valid;
  logic                    ws_allowin;
  logic [LANES-1:0]        lane_valid;
  logic [LANES-1:0]        lane_gr_we;
  logic [5*LANES-1:0]      lane_dest;
  logic [DATA_W*LANES-1:0] lane_result;
  logic [32*LANES-1:0]     lane_pc;
  logic [LANES-1:0]        lane_ex;
  logic [5*LANES-1:0]      lane_exccode;
  logic [LANES-1:0]        lane_eret;

  modport master (
    output ms_to_ws_valid, lane_valid, lane_gr_we,
    output lane_dest, lane_result, lane_pc,
    output lane_ex, lane_exccode, lane_eret,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, lane_valid, lane_gr_we,
    input  lane_dest, lane_result, lane_pc,
    input  lane_ex, lane_exccode, lane_eret,
    output ws_allowin
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Multi-lane writeback/commit stage: RF writes, exception/ERET flush,
// retire count, debug trace. Define WB_TRACE_FIFO_EN for the trace FIFO.
module wb_commit_unit #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_commit_unit_if.slave         ms,
  output logic [LANES-1:0]        rf_we,
  output logic [5*LANES-1:0]      rf_waddr,
  output logic [DATA_W*LANES-1:0] rf_wdata,
  output logic                    ex_commit,
  output logic [4:0]              ex_code,
  output logic [31:0]             ex_pc,
  output logic                    eret_commit,
  output logic                    flush,
  output logic [31:0]             retired_cnt,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  logic                    ws_valid_q;
  logic [LANES-1:0]        lv_q, gw_q, ex_q, eret_q;
  logic [5*LANES-1:0]      dest_q, exc_q;
  logic [DATA_W*LANES-1:0] res_q;
  logic [32*LANES-1:0]     pc_q;
  logic [31:0]             ret_q, ret_d;

  logic             ws_ready_go, ws_allowin, fire;
  logic [LANES-1:0] v, live, we_pre;
  logic             seen, sel_ex, sel_eret;
  logic [4:0]       sel_code;
  logic [31:0]      sel_pc, nret;

  assign ws_allowin    = !ws_valid_q || ws_ready_go;
  assign ms.ws_allowin = ws_allowin;
  assign fire          = ws_valid_q && ws_ready_go;

  // Input register; a flushing group discards whatever arrives with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      lv_q       <= '0;
      gw_q       <= '0;
      ex_q       <= '0;
      eret_q     <= '0;
      dest_q     <= '0;
      exc_q      <= '0;
      res_q      <= '0;
      pc_q       <= '0;
    end else begin
      if (flush) ws_valid_q <= 1'b0;
      else if (ws_allowin) ws_valid_q <= ms.ms_to_ws_valid;
      if (ms.ms_to_ws_valid && ws_allowin && !flush) begin
        lv_q   <= ms.lane_valid;
        gw_q   <= ms.lane_gr_we;
        ex_q   <= ms.lane_ex;
        eret_q <= ms.lane_eret;
        dest_q <= ms.lane_dest;
        exc_q  <= ms.lane_exccode;
        res_q  <= ms.lane_result;
        pc_q   <= ms.lane_pc;
      end
    end
  end

  // Kill mask, oldest-event select, pre-merge write enables, retire count.
  always_comb begin
    seen     = 1'b0;
    sel_ex   = 1'b0;
    sel_eret = 1'b0;
    sel_code = '0;
    sel_pc   = '0;
    v        = '0;
    live     = '0;
    we_pre   = '0;
    nret     = '0;
    for (int i = 0; i < LANES; i++) begin
      v[i]    = ws_valid_q && lv_q[i];
      live[i] = v[i] && !seen;
      if (live[i] && (ex_q[i] || eret_q[i])) begin
        sel_ex   = ex_q[i];
        sel_eret = eret_q[i] && !ex_q[i];
        sel_code = exc_q[5*i +: 5];
        sel_pc   = pc_q[32*i +: 32];
      end
      if (v[i] && (ex_q[i] || eret_q[i])) seen = 1'b1;
      we_pre[i] = fire && live[i] && gw_q[i] && !ex_q[i]
                  && (dest_q[5*i +: 5] != 5'd0);
      if (live[i] && !ex_q[i]) nret = nret + 32'd1;
    end
  end

  // A younger lane writing the same register shadows the older write.
  always_comb begin
    rf_we = we_pre;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (we_pre[j] && dest_q[5*j +: 5] == dest_q[5*i +: 5])
          rf_we[i] = 1'b0;
      end
    end
  end

  assign rf_waddr    = dest_q;
  assign rf_wdata    = res_q;
  assign ex_commit   = fire && sel_ex;
  assign eret_commit = fire && sel_eret;
  assign flush       = ex_commit || eret_commit;
  assign ex_code     = flush ? sel_code : 5'd0;
  assign ex_pc       = flush ? sel_pc : 32'd0;

  assign ret_d       = fire ? ret_q + nret : ret_q;
  assign retired_cnt = ret_q;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) ret_q <= '0;
    else       ret_q <= ret_d;
  end

`ifdef WB_TRACE_FIFO_EN
  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CW = $clog2(TRACE_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  num;
    logic [31:0] data;
  } trace_t;

  trace_t          mem_q [TRACE_DEPTH];
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d, npush;
  logic [PW-1:0]   off [LANES];
  logic            pop;

  assign ws_ready_go = (CW'(TRACE_DEPTH) - cnt_q) >= CW'(LANES);

  // Slot allocation for this cycle's pushes in lane order.
  always_comb begin
    npush = '0;
    for (int i = 0; i < LANES; i++) begin
      off[i] = wp_q + PW'(npush);
      if (we_pre[i]) npush = npush + CW'(1);
    end
    pop   = (cnt_q != '0);
    wp_d  = wp_q + PW'(npush);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + npush - CW'(pop);
  end

  // Trace pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Trace storage; contents are only observed while occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_pre[i])
        mem_q[off[i]] <= '{pc:   pc_q[32*i +: 32],
                           num:  dest_q[5*i +: 5],
                           data: 32'(res_q[DATA_W*i +: DATA_W])};
    end
  end

  assign debug_wb_rf_wen   = pop ? 4'hf : 4'h0;
  assign debug_wb_pc       = pop ? mem_q[rp_q].pc : 32'd0;
  assign debug_wb_rf_wnum  = pop ? mem_q[rp_q].num : 5'd0;
  assign debug_wb_rf_wdata = pop ? mem_q[rp_q].data : 32'd0;
`else
  // Without the FIFO nothing back-pressures; legal configs make this 1.
  assign ws_ready_go       = (TRACE_DEPTH >= LANES);
  assign debug_wb_rf_wen   = rf_we[0] ? 4'hf : 4'h0;
  assign debug_wb_pc       = rf_we[0] ? pc_q[31:0] : 32'd0;
  assign debug_wb_rf_wnum  = rf_we[0] ? dest_q[4:0] : 5'd0;
  assign debug_wb_rf_wdata = rf_we[0] ? 32'(res_q[DATA_W-1:0]) : 32'd0;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit.
// Table vectors plus flush, reset and trace sequences.
module tb_wb_commit_unit;
  localparam int L  = 2;
  localparam int DW = 32;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_commit_unit_if #(.LANES(L), .DATA_W(DW)) bus();

  logic [L-1:0]    rf_we;
  logic [5*L-1:0]  rf_waddr;
  logic [DW*L-1:0] rf_wdata;
  logic            ex_commit, eret_commit, flush;
  logic [4:0]      ex_code, dnum;
  logic [31:0]     ex_pc, retired_cnt, dpc, ddata;
  logic [3:0]      dwen;

  wb_commit_unit #(.LANES(L), .DATA_W(DW), .TRACE_DEPTH(TD)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms                (bus),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ex_commit         (ex_commit),
    .ex_code           (ex_code),
    .ex_pc             (ex_pc),
    .eret_commit       (eret_commit),
    .flush             (flush),
    .retired_cnt       (retired_cnt),
    .debug_wb_pc       (dpc),
    .debug_wb_rf_wen   (dwen),
    .debug_wb_rf_wnum  (dnum),
    .debug_wb_rf_wdata (ddata)
  );

  int total  = 0;
  int passed = 0;
  logic [31:0] exp_ret = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  lv, gw, ex, eret;
    logic [4:0]  d0, d1, c0, c1;
    logic [31:0] r0, r1, p0, p1;
    logic [1:0]  we;
    logic        exc, eretc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] inc;
  } vec_t;

  vec_t tv[10];

  task automatic drive(input vec_t t);
    bus.lane_valid   = t.lv;
    bus.lane_gr_we   = t.gw;
    bus.lane_ex      = t.ex;
    bus.lane_eret    = t.eret;
    bus.lane_dest    = {t.d1, t.d0};
    bus.lane_exccode = {t.c1, t.c0};
    bus.lane_result  = {t.r1, t.r0};
    bus.lane_pc      = {t.p1, t.p0};
  endtask

  vec_t g;
  int   gi, got, dropped;
  logic [31:0] tp[12], tdat[12];
  logic [4:0]  tn[12];

  initial begin
    reset = 1'b1;
    bus.ms_to_ws_valid = 1'b0;
    drive('{2'b0, 2'b0, 2'b0, 2'b0, 5'd0, 5'd0, 5'd0, 5'd0,
            32'd0, 32'd0, 32'd0, 32'd0, 2'b0, 1'b0, 1'b0,
            5'd0, 32'd0, 32'd0});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 64'(bus.ws_allowin), 64'd1);
    chk("rst_retired", 64'(retired_cnt), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_dwen", 64'(dwen), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_ex_code", 64'(ex_code), 64'd0);

    // lv gw ex eret d0 d1 c0 c1 r0 r1 p0 p1 we exc eretc code epc inc
    tv[0] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd5, 5'd6, 5'd0, 5'd0,
              32'h11, 32'h22, 32'hbfc00000, 32'hbfc00004,
              2'b11, 1'b0, 1'b0, 5'd0, 32'd0, 32'd2};
    tv[1] = '{2'b11, 2'b11, 2'b01, 2'b00, 5'd3, 5'd7, 5'h0c, 5'd0,
              32'h33, 32'h77, 32'h100, 32'h104,
              2'b00, 1'b1, 1'b0, 5'h0c, 32'h100, 32'd0};
    tv[2] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd8, 5'd8, 5'd0, 5'd0,
              32'h1, 32'h2, 32'h110, 32'h114,
              2'b10, 1'b0, 1'b0, 5'd0, 32'd0, 32'd2};
    tv[3] = '{2'b11, 2'b10, 2'b00, 2'b01, 5'd0, 5'd9, 5'd0, 5'd0,
              32'h0, 32'h99, 32'h200, 32'h204,
              2'b00, 1'b0, 1'b1, 5'd0, 32'h200, 32'd1};
    tv[4] = '{2'b10, 2'b11, 2'b00, 2'b00, 5'd4, 5'd10, 5'd0, 5'd0,
              32'h44, 32'haa, 32'h210, 32'h214,
              2'b10, 1'b0, 1'b0, 5'd0, 32'd0, 32'd1};
    tv[5] = '{2'b11, 2'b11, 2'b00, 2'b00, 5'd0, 5'd3, 5'd0, 5'd0,
              32'h55, 32'h66, 32'h220, 32'h224,
              2'b10, 1'b0, 1'b0, 5'd0, 32'd0, 32'd2};
    tv[6] = '{2'b11, 2'b11, 2'b10, 2'b00, 5'd4, 5'd12, 5'd0, 5'h04,
              32'h4444, 32'hcc, 32'h300, 32'h304,
              2'b01, 1'b1, 1'b0, 5'h04, 32'h304, 32'd1};
    tv[7] = '{2'b11, 2'b11, 2'b01, 2'b01, 5'd2, 5'd13, 5'h08, 5'd0,
              32'h2, 32'hd, 32'h400, 32'h404,
              2'b00, 1'b1, 1'b0, 5'h08, 32'h400, 32'd0};
    tv[8] = '{2'b11, 2'b00, 2'b00, 2'b00, 5'd14, 5'd15, 5'd0, 5'd0,
              32'he, 32'hf, 32'h500, 32'h504,
              2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd2};
    tv[9] = '{2'b00, 2'b11, 2'b00, 2'b00, 5'd16, 5'd17, 5'd0, 5'd0,
              32'h10, 32'h11, 32'h600, 32'h604,
              2'b00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 drive(tv[i]);
      bus.ms_to_ws_valid = 1'b1;
      @(posedge clk);
      #1 bus.ms_to_ws_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(tv[i].we));
      chk($sformatf("v%0d_ex", i), 64'(ex_commit), 64'(tv[i].exc));
      chk($sformatf("v%0d_eret", i), 64'(eret_commit),
          64'(tv[i].eretc));
      chk($sformatf("v%0d_flush", i), 64'(flush),
          64'(tv[i].exc | tv[i].eretc));
      chk($sformatf("v%0d_code", i), 64'(ex_code), 64'(tv[i].code));
      chk($sformatf("v%0d_epc", i), 64'(ex_pc), 64'(tv[i].epc));
`ifndef WB_TRACE_FIFO_EN
      chk($sformatf("v%0d_dwen", i), 64'(dwen),
          tv[i].we[0] ? 64'hf : 64'h0);
      if (tv[i].we[0]) begin
        chk($sformatf("v%0d_dpc", i), 64'(dpc), 64'(tv[i].p0));
        chk($sformatf("v%0d_dnum", i), 64'(dnum), 64'(tv[i].d0));
        chk($sformatf("v%0d_ddat", i), 64'(ddata), 64'(tv[i].r0));
      end
`endif
      exp_ret = exp_ret + tv[i].inc;
      @(posedge clk);
      #1 chk($sformatf("v%0d_retired", i), 64'(retired_cnt),
             64'(exp_ret));
      repeat (3) @(posedge clk);
    end

    // Exception group followed immediately by a group that must die.
    @(posedge clk);
    #1 drive(tv[1]);
    bus.ms_to_ws_valid = 1'b1;
    @(posedge clk);
    #1 g = tv[0];
    g.d0 = 5'd11;
    g.d1 = 5'd12;
    drive(g);
    @(negedge clk);
    chk("flush_pulse", 64'(flush), 64'd1);
    chk("flush_code", 64'(ex_code), 64'h0c);
    @(posedge clk);
    #1 bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("flush_discard_we", 64'(rf_we), 64'd0);
    chk("flush_no_repeat", 64'(flush), 64'd0);
    chk("flush_retired", 64'(retired_cnt), 64'(exp_ret));
    repeat (4) @(posedge clk);

`ifdef WB_TRACE_FIFO_EN
    // Back-to-back full groups against a 4-entry trace FIFO.
    for (int k = 0; k < 6; k++) begin
      for (int n = 0; n < 2; n++) begin
        tp[2*k+n]   = 32'h1000 + 32'(8*k + 4*n);
        tn[2*k+n]   = 5'(2*k + n + 1);
        tdat[2*k+n] = 32'(16*k + n + 1);
      end
    end
    gi = 0;
    got = 0;
    dropped = 0;
    for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
      @(posedge clk);
      #1;
      if (gi < 6) begin
        g = tv[0];
        g.d0 = tn[2*gi];
        g.d1 = tn[2*gi+1];
        g.r0 = tdat[2*gi];
        g.r1 = tdat[2*gi+1];
        g.p0 = tp[2*gi];
        g.p1 = tp[2*gi+1];
        drive(g);
        bus.ms_to_ws_valid = 1'b1;
      end else begin
        bus.ms_to_ws_valid = 1'b0;
      end
      @(negedge clk);
      if (!bus.ws_allowin) dropped = 1;
      if (dwen == 4'hf && got < 12) begin
        chk($sformatf("tr%0d_pc", got), 64'(dpc), 64'(tp[got]));
        chk($sformatf("tr%0d_num", got), 64'(dnum), 64'(tn[got]));
        chk($sformatf("tr%0d_dat", got), 64'(ddata), 64'(tdat[got]));
        got++;
      end
      if (bus.ms_to_ws_valid && bus.ws_allowin) gi++;
    end
    bus.ms_to_ws_valid = 1'b0;
    chk("trace_count", 64'(got), 64'd12);
    chk("allowin_dropped", 64'(dropped), 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("trace_empty", 64'(dwen), 64'd0);
    exp_ret = exp_ret + 32'd12;
    chk("trace_retired", 64'(retired_cnt), 64'(exp_ret));
`endif

    // Reset arriving together with a group drops it.
    @(posedge clk);
    #1 drive(tv[0]);
    bus.ms_to_ws_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", 64'(rf_we), 64'd0);
    chk("rst_mid_retired", 64'(retired_cnt), 64'd0);
    chk("rst_mid_allowin", 64'(bus.ws_allowin), 64'd1);
    chk("rst_mid_dwen", 64'(dwen), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
